// File: rtl/vga_pkg.sv
`default_nettype none
// vga_pkg: shared 640x480@60 raster constants, counter width and sync-bundle type.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int MAX_SYNC_DELAY = 7;

  typedef struct packed {
    logic visible;
    logic hsync;
    logic vsync;
  } sync_t;

  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sig_delay.sv
`default_nettype none
// sig_delay: enable-gated shift register; every stage loads RESET_VAL on reset.
module sig_delay #(
  parameter int                WIDTH     = 1,
  parameter int                DEPTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
        end else if (en) begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// vga_timing: raster counters with delayed hsync/vsync/visible and an undelayed frame_start pulse.
module vga_timing
  import vga_pkg::*;
#(
  parameter int C_H_VISIBLE  = H_VISIBLE,
  parameter int C_H_FRONT    = H_FRONT,
  parameter int C_H_SYNC     = H_SYNC,
  parameter int C_H_BACK     = H_BACK,
  parameter int C_V_VISIBLE  = V_VISIBLE,
  parameter int C_V_FRONT    = V_FRONT,
  parameter int C_V_SYNC     = V_SYNC,
  parameter int C_V_BACK     = V_BACK,
  parameter bit C_HSYNC_POL  = 1'b0,
  parameter bit C_VSYNC_POL  = 1'b0,
  parameter int C_SYNC_DELAY = 2
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             iclk_en,
  output logic [CNT_W-1:0] vga_x,
  output logic [CNT_W-1:0] vga_y,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic             frame_start
);

  localparam int HT = C_H_VISIBLE + C_H_FRONT + C_H_SYNC + C_H_BACK;
  localparam int VT = C_V_VISIBLE + C_V_FRONT + C_V_SYNC + C_V_BACK;
  localparam int HS_START = C_H_VISIBLE + C_H_FRONT;
  localparam int VS_START = C_V_VISIBLE + C_V_FRONT;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(VT - 1);

  localparam sync_t SYNC_IDLE = '{visible: 1'b0, hsync: ~C_HSYNC_POL, vsync: ~C_VSYNC_POL};

  generate
    if (HT > (1 << CNT_W) || VT > (1 << CNT_W) || HT < 2 || VT < 1 ||
        C_H_VISIBLE < 0 || C_H_FRONT < 0 || C_H_SYNC < 0 || C_H_BACK < 0 ||
        C_V_VISIBLE < 0 || C_V_FRONT < 0 || C_V_SYNC < 0 || C_V_BACK < 0 ||
        C_SYNC_DELAY < 0 || C_SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_params
      $error("vga_timing: illegal timing parameters");
    end
  endgenerate

  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  sync_t            raw_nxt;
  sync_t            sync_q;

  always_comb begin
    x_nxt = vga_x + 1'b1;
    y_nxt = vga_y;
    if (vga_x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (vga_y == Y_LAST) ? '0 : vga_y + 1'b1;
    end
  end

  // Raw sync is evaluated on the next coordinates, so a delay line one stage
  // longer than C_SYNC_DELAY yields exactly C_SYNC_DELAY periods of lag.
  always_comb begin
    raw_nxt.visible = (int'(x_nxt) < C_H_VISIBLE) && (int'(y_nxt) < C_V_VISIBLE);
    raw_nxt.hsync   = in_window(int'(x_nxt), HS_START, HS_START + C_H_SYNC) ? C_HSYNC_POL : ~C_HSYNC_POL;
    raw_nxt.vsync   = in_window(int'(y_nxt), VS_START, VS_START + C_V_SYNC) ? C_VSYNC_POL : ~C_VSYNC_POL;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      vga_x       <= '0;
      vga_y       <= '0;
      frame_start <= 1'b0;
    end else if (iclk_en) begin
      vga_x       <= x_nxt;
      vga_y       <= y_nxt;
      frame_start <= (x_nxt == '0) && (y_nxt == '0);
    end
  end

  sig_delay #(
    .WIDTH     ($bits(sync_t)),
    .DEPTH     (C_SYNC_DELAY + 1),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (iclk),
    .rst  (irst),
    .en   (iclk_en),
    .din  (raw_nxt),
    .dout (sync_q)
  );

  assign visible = sync_q.visible;
  assign hsync   = sync_q.hsync;
  assign vsync   = sync_q.vsync;

endmodule
`default_nettype wire
